// File: rtl/alu_sched.sv
// Two-port round-robin scheduler in front of a shared 8-bit ALU (IDLE -> EXEC -> RESP).
// Optional ALU_SCHED_DIVZ_EN: divide-by-zero yields 8'hFF with rsp_err set; otherwise 8'h00, rsp_err tied low.
module alu_sched #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [OPW-1:0]   op0,
    input  logic [OPW-1:0]   op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic             prio1;
    logic [OPW-1:0]   op_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic             id_p0;

    function automatic logic [WIDTH-1:0] alu_op(input logic [OPW-1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        res = '0;
        case (4'(op))
            4'h0: res = a + b;
            4'h1: res = a - b;
            4'h2: res = a * b;
            4'h3: begin
`ifdef ALU_SCHED_DIVZ_EN
                if (b == '0) res = '1;
`else
                if (b == '0) res = '0;
`endif
                else res = a / b;
            end
            4'h4: res = a & b;
            4'h5: res = a | b;
            4'h6: res = ~(a & b);
            4'h7: res = ~(a | b);
            4'h8: res = a + ONE;
            4'h9: res = a - ONE;
            4'hA: res = a ^ b;
            4'hB: res = a >> 1;
            4'hC: res = a << 1;
            4'hD: res = a + b + ONE;
            4'hE: res = a - b - ONE;
            4'hF: res = b + ONE;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Grant only from IDLE; prio1 marks port 1 as the favoured port on a tie.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (req0 || req1)) begin
                    if (req1 && (!req0 || prio1)) gnt1 = 1'b1;
                    else                          gnt0 = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);

    // Stage p0: capture the granted request's operands.
    always_ff @(posedge clk) begin
        if (gnt0 || gnt1) begin
            op_p0 <= gnt1 ? op1 : op0;
            a_p0  <= gnt1 ? a1  : a0;
            b_p0  <= gnt1 ? b1  : b0;
            id_p0 <= gnt1;
        end
    end

    // Stage p1: EXEC registers the result held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio1    <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (gnt0 || gnt1) prio1 <= gnt0;
            if (state == EXEC) begin
                rsp_data <= alu_op(op_p0, a_p0, b_p0);
                rsp_id   <= id_p0;
            end
        end
    end

`ifdef ALU_SCHED_DIVZ_EN
    always_ff @(posedge clk) begin
        if (rst)                 rsp_err <= 1'b0;
        else if (state == EXEC)  rsp_err <= (4'(op_p0) == 4'h3) && (b_p0 == '0);
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched: arbitration, latency, back-pressure, reset, opcode results.
module tb_alu_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] rsp_data;

    int total = 0;
    int fails = 0;

    alu_sched #(.WIDTH(8), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One complete transaction with rsp_ready high; expected result supplied by caller.
    task automatic run_op(input int port, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_d,
                          input logic exp_e, input string tag);
        rsp_ready = 1'b1;
        if (port == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else           begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        #1;
        chk({tag, "_gnt"}, (port == 0) ? gnt0 : gnt1, 1);
        chk({tag, "_gnt_other"}, (port == 0) ? gnt1 : gnt0, 0);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_id"}, rsp_id, port[0]);
        chk({tag, "_err"}, rsp_err, exp_e);
        tick();
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b0; rsp_ready = 1'b0;
        op0 = 4'h0; op1 = 4'h0; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
        tick();
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 8'h00);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
        req0 = 1'b0;
        rst = 1'b0;
        tick();

        // Basic add with wrap, 2-cycle latency
        run_op(0, 4'h0, 8'hF0, 8'h20, 8'h10, 1'b0, "add_wrap");

        // Both requesting after reset: grants alternate starting with port 0
        do_reset();
        rsp_ready = 1'b1;
        req0 = 1'b1; op0 = 4'h0; a0 = 8'h01; b0 = 8'h01;
        req1 = 1'b1; op1 = 4'h4; a1 = 8'hFF; b1 = 8'h0F;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d_gnt0", k), gnt0, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_gnt1", k), gnt1, (k % 2 == 1) ? 1 : 0);
            tick();
            chk($sformatf("rr%0d_exec_gnt", k), gnt0 | gnt1, 0);
            tick();
            chk($sformatf("rr%0d_id", k), rsp_id, k % 2);
            chk($sformatf("rr%0d_data", k), rsp_data, (k % 2 == 0) ? 8'h02 : 8'h0F);
            tick();
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Back-pressure: multiply held 5 cycles, waiting request not granted early
        rsp_ready = 1'b0;
        req0 = 1'b1; op0 = 4'h2; a0 = 8'h10; b0 = 8'h11;
        #1;
        chk("bp_gnt0", gnt0, 1);
        tick();
        req0 = 1'b0;
        req1 = 1'b1; op1 = 4'h8; a1 = 8'h05; b1 = 8'h00;
        #1;
        chk("bp_exec_gnt1", gnt1, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
            chk($sformatf("bp%0d_data", k), rsp_data, 8'h10);
            chk($sformatf("bp%0d_gnt1", k), gnt1, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_gnt1", gnt1, 0);
        tick();
        chk("bp_idle_valid", rsp_valid, 0);
        chk("bp_pending_gnt1", gnt1, 1);
        tick();
        req1 = 1'b0;
        tick();
        chk("bp_inc_data", rsp_data, 8'h06);
        chk("bp_inc_id", rsp_id, 1);
        tick();

        // Divide, including divide by zero
        run_op(0, 4'h3, 8'h64, 8'h07, 8'h0E, 1'b0, "div");
`ifdef ALU_SCHED_DIVZ_EN
        run_op(1, 4'h3, 8'h07, 8'h00, 8'hFF, 1'b1, "div0");
`else
        run_op(1, 4'h3, 8'h07, 8'h00, 8'h00, 1'b0, "div0");
`endif

        // Shifts and remaining opcodes
        run_op(0, 4'hB, 8'h81, 8'h00, 8'h40, 1'b0, "shr");
        run_op(1, 4'hC, 8'h81, 8'h00, 8'h02, 1'b0, "shl");
        run_op(0, 4'h1, 8'h05, 8'h07, 8'hFE, 1'b0, "sub");
        run_op(1, 4'h5, 8'h0F, 8'h30, 8'h3F, 1'b0, "or");
        run_op(0, 4'h6, 8'hF0, 8'h3C, 8'hCF, 1'b0, "nand");
        run_op(1, 4'h7, 8'h0F, 8'h30, 8'hC0, 1'b0, "nor");
        run_op(0, 4'h9, 8'h00, 8'h00, 8'hFF, 1'b0, "dec");
        run_op(1, 4'hA, 8'hAA, 8'hFF, 8'h55, 1'b0, "xor");
        run_op(0, 4'hD, 8'hFF, 8'h01, 8'h01, 1'b0, "addc");
        run_op(1, 4'hE, 8'h00, 8'h00, 8'hFF, 1'b0, "subb");
        run_op(0, 4'hF, 8'h12, 8'hFF, 8'h00, 1'b0, "incb");

        // Reset while in RESP drops the response; pending request granted afterwards
        rsp_ready = 1'b0;
        req0 = 1'b1; op0 = 4'h0; a0 = 8'h01; b0 = 8'h02;
        #1;
        chk("rr_rst_gnt0", gnt0, 1);
        tick();
        req0 = 1'b0;
        tick();
        chk("rr_rst_valid_before", rsp_valid, 1);
        req1 = 1'b1; op1 = 4'h0; a1 = 8'h03; b1 = 8'h03;
        rst = 1'b1;
        #1;
        chk("rst_resp_gnt1", gnt1, 0);
        tick();
        rst = 1'b0;
        chk("rst_resp_valid", rsp_valid, 0);
        chk("rst_resp_data", rsp_data, 8'h00);
        #1;
        chk("rst_pending_gnt1", gnt1, 1);
        tick();
        req1 = 1'b0;
        tick();
        chk("rst_pending_valid", rsp_valid, 1);
        chk("rst_pending_data", rsp_data, 8'h06);
        chk("rst_pending_id", rsp_id, 1);
        rsp_ready = 1'b1;
        tick();
        chk("final_idle_valid", rsp_valid, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand/result width; only 8 is supported, matching the shared 8-bit ALU datapath.
REQ-002 The block SHALL have parameter OPW, default 4: opcode width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have ports req0/req1, input, 1 each: requester 0/1 wants an ALU operation.
REQ-006 The block SHALL have ports op0/op1, input, OPW each: requested opcode.
REQ-007 The block SHALL have ports a0/b0/a1/b1, input, WIDTH each: operands.
REQ-008 The block SHALL have ports gnt0/gnt1, output, 1 each: request accepted this cycle (combinational, one-hot).
REQ-009 The block SHALL have port rsp_valid, output, 1: result available.
REQ-010 The block SHALL have port rsp_ready, input, 1: consumer accepts result.
REQ-011 The block SHALL have port rsp_id, output, 1: requester that owns the result.
REQ-012 The block SHALL have port rsp_data, output, WIDTH: result.
REQ-013 The block SHALL have port rsp_err, output, 1: divide-by-zero flag.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP.
REQ-015 In IDLE with any reqN high, the block SHALL assert exactly one gntN that cycle and capture that port's opN/aN/bN at the clock edge, then enter EXEC; with no request it SHALL stay in IDLE.
REQ-016 gnt0/gnt1 SHALL be low in EXEC and RESP; requesters hold req and operands stable until granted.
REQ-017 Arbitration SHALL be round-robin: with req0 and req1 both high, the port not granted last wins; the single requester wins otherwise.
REQ-018 In EXEC (one cycle), the block SHALL compute the result from the captured operands and register rsp_data/rsp_id/rsp_err, then enter RESP.
REQ-019 Opcode map SHALL be: 0 a+b, 1 a-b, 2 a*b, 3 a/b, 4 a&b, 5 a|b, 6 ~(a&b), 7 ~(a|b), 8 a+1, 9 a-1, A a^b, B a>>1, C a<<1, D a+b+1, E a-b-1, F b+1.
REQ-020 All results SHALL be truncated to the low WIDTH bits (mod 256 wrap; a*b keeps the low 8 bits; shifts are logical).
REQ-021 In RESP, rsp_valid SHALL be high with rsp_data/rsp_id/rsp_err stable until the cycle rsp_ready is high, after which the state returns to IDLE.
REQ-022 Grant-to-rsp_valid latency SHALL be 2 cycles; the next grant can occur at the earliest in the cycle after the rsp_valid/rsp_ready handshake (throughput 1 op per 3 cycles at full rate).
REQ-023 A request arriving while the block is not in IDLE SHALL wait and SHALL NOT be lost or granted early.
REQ-024 rsp_err SHALL be 0 for every opcode other than 3.

Reset
REQ-025 While rst is high at a clock edge, the state SHALL go to IDLE, rsp_valid/rsp_err/rsp_id SHALL be 0, rsp_data SHALL be 8'h00, and the round-robin pointer SHALL favour port 0.
REQ-026 gnt0/gnt1 SHALL be 0 while rst is high.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation with no response issued.

Configuration
REQ-028 Macro ALU_SCHED_DIVZ_EN SHALL control divide-by-zero detection.
REQ-029 With ALU_SCHED_DIVZ_EN defined, opcode 3 with b=0 SHALL give rsp_data=8'hFF and rsp_err=1.
REQ-030 Without ALU_SCHED_DIVZ_EN, opcode 3 with b=0 SHALL give rsp_data=8'h00, and rsp_err SHALL be tied to 0.

Verification
REQ-031 The bench SHALL cover: req0 only, op0=0, a0=8'hF0, b0=8'h20 -> gnt0 that cycle; 2 cycles later rsp_valid=1, rsp_data=8'h10, rsp_id=0.
REQ-032 The bench SHALL cover: req0 and req1 both held high, rsp_ready=1 throughout -> grants alternate 0,1,0,1 starting with port 0 after reset.
REQ-033 The bench SHALL cover: op=2, a=8'h10, b=8'h11 with rsp_ready=0 for 5 cycles -> rsp_data=8'h10 held stable, no new grant until rsp_ready rises.
REQ-034 The bench SHALL cover: op=3, a=8'h07, b=8'h00 -> rsp_data=8'hFF with rsp_err=1 (macro defined), or rsp_data=8'h00 with rsp_err=0 (macro undefined).
REQ-035 The bench SHALL cover: rst asserted for 1 cycle while in RESP -> next cycle rsp_valid=0, state IDLE, the pending request is granted afterwards.
REQ-036 The bench SHALL cover: opcodes B and C with a=8'h81 -> rsp_data=8'h40 and 8'h02 respectively.
